// File: rtl/ab_seq_ctrl.sv
// ab_seq_ctrl: sequencer driving the A/B excitation inputs of an external bank
// of four AB flip-flops (00 hold, 01 set, 10 reset, 11 toggle). A command
// (count up, count down, load, clear) is accepted in IDLE, executed in RUN for
// a counted number of non-held cycles, and acknowledged by a one-cycle DONE.
// Excitation is derived from the live flop feedback q so each RUN step moves
// the bank to its target in a single edge without ever issuing the toggle code.
module ab_seq_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [3:0] data,
    input  logic [3:0] steps,
    input  logic       hold,
    input  logic [3:0] q,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_UP  = 2'b00;
    localparam logic [1:0] MODE_DN  = 2'b01;
    localparam logic [1:0] MODE_LD  = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] mode_q,  mode_d;
    logic [3:0] data_q,  data_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] target;
    logic       drive_en;

    // State register; reset aborts any command in flight immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched command and remaining-step counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_UP;
            data_q <= 4'h0;
            cnt_q  <= 4'h0;
        end else begin
            mode_q <= mode_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, count non-held RUN cycles, single DONE.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    mode_d  = mode;
                    data_d  = data;
                    // Load and clear complete in one step; counts use steps
                    // directly, and a zero count still spends one RUN cycle.
                    cnt_d   = mode[1] ? 4'd1 : steps;
                end
            end
            S_RUN: begin
                if (!hold) begin
                    if (cnt_q <= 4'd1) begin
                        state_d = S_DONE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Target value the flop bank should hold after the current RUN edge.
    always_comb begin
        target = q;
        unique case (mode_q)
            MODE_UP:  target = q + 4'd1;
            MODE_DN:  target = q - 4'd1;
            MODE_LD:  target = data_q;
            MODE_CLR: target = 4'h0;
            default:  target = q;
        endcase
    end

    // Outputs: status from state; excitation only on active, non-held RUN steps.
    always_comb begin
        busy     = (state_q == S_RUN);
        done     = (state_q == S_DONE);
        // cnt_q is zero in RUN only for a zero-step count, which must leave q alone.
        drive_en = (state_q == S_RUN) && !hold && (cnt_q != 4'd0);
        a        = 4'h0;
        b        = 4'h0;
        if (drive_en) begin
            // Set where a 0 must become 1, reset where a 1 must become 0;
            // the two masks are disjoint so AB=11 never appears.
            a = q & ~target;
            b = ~q & target;
        end
    end

endmodule

// File: tb/tb_ab_seq_ctrl.sv
// tb_ab_seq_ctrl: bench for ab_seq_ctrl with a behavioural model of the
// external AB flip-flop bank closing the q feedback loop.
module tb_ab_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic [3:0] data;
    logic [3:0] steps;
    logic       hold;
    logic [3:0] q;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;

    logic       ld;
    logic [3:0] ld_val;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] m;
        logic [3:0] d;
        logic [3:0] s;
        logic [3:0] q0;
        logic [3:0] exp_q;
        int         exp_busy;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    ab_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mode  (mode),
        .data  (data),
        .steps (steps),
        .hold  (hold),
        .q     (q),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done)
    );

    // External bank of four AB flip-flops; ld lets the bench preset it.
    always @(posedge clk) begin
        if (ld) begin
            q <= ld_val;
        end else begin
            for (int i = 0; i < 4; i++) begin
                case ({a[i], b[i]})
                    2'b01:   q[i] <= 1'b1;
                    2'b10:   q[i] <= 1'b0;
                    2'b11:   q[i] <= ~q[i];
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One step of a command applied to the value v.
    function automatic logic [3:0] step_val(input logic [1:0] m, input logic [3:0] d, input logic [3:0] v);
        case (m)
            2'b00:   return v + 4'd1;
            2'b01:   return v - 4'd1;
            2'b10:   return d;
            default: return 4'h0;
        endcase
    endfunction

    // Final bank value of a whole command in closed form.
    function automatic logic [3:0] final_val(input logic [1:0] m, input logic [3:0] d,
                                             input logic [3:0] s, input logic [3:0] q0);
        case (m)
            2'b00:   return q0 + s;
            2'b01:   return q0 - s;
            2'b10:   return d;
            default: return 4'h0;
        endcase
    endfunction

    // Entered and left at one time unit after a rising edge.
    task automatic set_q(input logic [3:0] v);
        ld     = 1'b1;
        ld_val = v;
        @(posedge clk); #1;
        ld     = 1'b0;
    endtask

    // Issue one command from IDLE and follow it until the DUT is back in IDLE.
    task automatic do_cmd(input logic [1:0] m, input logic [3:0] d, input logic [3:0] s,
                          input logic [31:0] hmask, input bit noise,
                          output int busy_tot, output int done_tot, output logic [3:0] qfin);
        logic [3:0] q0;
        logic [3:0] expq;
        int         n_eff;
        int         k;
        int         nh;
        bit         h;
        bit         fin;
        bit         was_busy;
        q0       = q;
        expq     = q;
        n_eff    = m[1] ? 1 : int'(s);
        k        = 0;
        nh       = 0;
        busy_tot = 0;
        done_tot = 0;
        fin      = 1'b0;
        start = 1'b1; mode = m; data = d; steps = s; hold = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
            h    = (cyc < 32) ? hmask[cyc] : 1'b0;
            hold = h;
            if (noise) begin
                start = 1'($urandom);
                mode  = 2'($urandom);
                data  = 4'($urandom);
                steps = 4'($urandom);
            end
            #1;
            if (!busy && !done) begin
                fin   = 1'b1;
                start = 1'b0;
                hold  = 1'b0;
            end else begin
                if (busy) begin
                    busy_tot++;
                    check("ab_overlap", a & b, 0);
                    if (h || k >= n_eff) check("ab_quiet_run", {a, b}, 0);
                end else begin
                    done_tot++;
                    check("ab_done", {a, b}, 0);
                end
                was_busy = busy;
                @(posedge clk); #1;
                if (was_busy && !h) begin
                    if (k < n_eff) expq = step_val(m, d, expq);
                    k++;
                    nh++;
                    check("q_seq", q, expq);
                end
            end
        end
        if (!fin) begin
            n_vec++;
            n_err++;
            $display("FAIL cmd_timeout: got no return to idle, expected idle within 64 cycles");
            start = 1'b0;
            hold  = 1'b0;
        end
        check("done_pulses", done_tot, 1);
        check("busy_active", nh, (n_eff == 0) ? 1 : n_eff);
        check("q_final", q, final_val(m, d, s, q0));
        qfin = q;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000 time units");
        $fatal(1);
    end

    initial begin
        int         bt;
        int         dt;
        logic [3:0] qf;
        logic [1:0] rm;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [31:0] rh;

        tbl[0] = '{2'b00, 4'h0, 4'd3,  4'hE, 4'h1, 3};
        tbl[1] = '{2'b10, 4'hA, 4'd7,  4'h5, 4'hA, 1};
        tbl[2] = '{2'b11, 4'h6, 4'd9,  4'h9, 4'h0, 1};
        tbl[3] = '{2'b01, 4'h0, 4'd2,  4'h0, 4'hE, 2};
        tbl[4] = '{2'b00, 4'h0, 4'd0,  4'h7, 4'h7, 1};
        tbl[5] = '{2'b01, 4'h0, 4'd15, 4'h3, 4'h4, 15};
        tbl[6] = '{2'b00, 4'h0, 4'd1,  4'hF, 4'h0, 1};

        reset = 1'b1; start = 1'b0; hold = 1'b0;
        mode = 2'b00; data = 4'h0; steps = 4'h0;
        ld = 1'b1; ld_val = 4'h3;
        @(posedge clk); #1;
        ld = 1'b0;

        // Start a 5-step count from q=3, then reset asynchronously mid-cycle.
        reset = 1'b0;
        start = 1'b1; mode = 2'b00; steps = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check("run_busy", busy, 1);
        check("run_a", a, 4'b0011);
        check("run_b", b, 4'b0100);
        reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ab", {a, b}, 0);

        // start while reset is held is ignored.
        start = 1'b1;
        @(posedge clk); #1;
        check("rst_start_ign", busy, 0);
        check("rst_q_kept", q, 4'h3);
        reset = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_after_rst", busy, 1);

        // Reset in the second cycle of a 5-step count.
        @(posedge clk); #1;
        check("cnt5_q1", q, 4'h4);
        check("cnt5_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ab", {a, b}, 0);
        @(posedge clk); #1;
        check("abort_q_kept", q, 4'h4);
        reset = 1'b0;
        do_cmd(2'b10, 4'h9, 4'd0, 32'h0, 1'b0, bt, dt, qf);
        check("post_abort_q", qf, 4'h9);

        // Load 5 -> A: exact excitation during the single RUN cycle.
        set_q(4'h5);
        start = 1'b1; mode = 2'b10; data = 4'hA;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        check("ld_a", a, 4'b0101);
        check("ld_b", b, 4'b1010);
        @(posedge clk); #1;
        check("ld_q", q, 4'hA);
        check("ld_done", done, 1);
        check("ld_busy_off", busy, 0);
        @(posedge clk); #1;
        check("ld_done_once", done, 0);

        // Table of hold-free commands.
        for (int i = 0; i < 7; i++) begin
            set_q(tbl[i].q0);
            do_cmd(tbl[i].m, tbl[i].d, tbl[i].s, 32'h0, 1'b0, bt, dt, qf);
            check("tbl_q", qf, tbl[i].exp_q);
            check("tbl_busy", bt, tbl[i].exp_busy);
        end

        // Count down 2 from 1 with hold in the second and third busy cycles.
        set_q(4'h1);
        do_cmd(2'b01, 4'h0, 4'd2, 32'h6, 1'b0, bt, dt, qf);
        check("hold_busy", bt, 4);
        check("hold_q", qf, 4'hF);

        // Zero-step count with start and command noise while busy.
        set_q(4'h7);
        do_cmd(2'b00, 4'h0, 4'd0, 32'h0, 1'b1, bt, dt, qf);
        check("zero_busy", bt, 1);
        check("zero_q", qf, 4'h7);

        // Back-to-back random commands with random holds and input noise.
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0) set_q(4'($urandom));
            rm = 2'($urandom);
            rd = 4'($urandom);
            rs = 4'($urandom);
            rh = $urandom & $urandom & $urandom;
            do_cmd(rm, rd, rs, rh, 1'b1, bt, dt, qf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
